hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage core.
- Sits beside the IF/ID, ID/EX and EX/MEM pipeline registers and drives their write-enable, hold and flush controls:
  - load-use bubbles into ID/EX;
  - IF/ID + ID/EX squash on taken branch/JAL;
  - whole-pipe freeze while data memory is busy.
- Also keeps a memory-wait watchdog and saturating stall/flush performance counters.

Parameters:
- REGADDR_WIDTH, 4: width of register-file addresses.
- ZERO_REG_HARDWIRED, 1: when 1, register 0 never causes a load-use hazard.
- MEM_TIMEOUT, 64: consecutive mem_busy cycles after which mem_timeout is raised.
- CNT_WIDTH, 16: width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset; sampled only at posedge clk.
- id_rs  in  REGADDR_WIDTH  source register 1 of the instruction in ID.
- id_rt  in  REGADDR_WIDTH  source register 2 of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads id_rs.
- id_uses_rt  in  1  ID instruction reads id_rt.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_dest  in  REGADDR_WIDTH  destination register of the instruction in EX.
- ex_redirect  in  1  EX resolved a taken branch or a JAL this cycle.
- mem_busy  in  1  data memory cannot complete the MEM-stage access this cycle.
- pc_write  out  1  PC register enable.
- if_id_write  out  1  IF/ID enable.
- if_id_flush  out  1  IF/ID squash.
- id_ex_flush  out  1  ID/EX squash (bubble).
- id_ex_hold  out  1  ID/EX hold.
- ex_mem_hold  out  1  EX/MEM hold.
- stall_cause  out  2  registered cause of the previous cycle: 0 none, 1 load-use, 2 redirect, 3 mem wait.
- mem_timeout  out  1  sticky watchdog error.
- stall_cnt  out  CNT_WIDTH  saturating count of cycles with pc_write=0.
- flush_cnt  out  CNT_WIDTH  saturating count of redirect squashes.

Behaviour:
- Decisions are combinational from the current inputs, so they take effect in the same cycle. The FSM, watchdog and counters are registered.
- Hazard definition: lu_hazard = ex_mem_read & (ex_dest matches id_rs with id_uses_rs, or ex_dest matches id_rt with id_uses_rt) & !(ZERO_REG_HARDWIRED & ex_dest==0).
- Priority (highest first): reset > mem_busy > ex_redirect > lu_hazard > run.
- Reset (while reset=1):
  - pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, id_ex_hold=0, ex_mem_hold=0.
  - State=RUN, stall_cause=0, mem_timeout=0, watchdog=0, stall_cnt=0, flush_cnt=0.
  - Reset mid-stall abandons the stall; there is no carry-over.
- mem_busy=1:
  - pc_write=0, if_id_write=0, id_ex_hold=1, ex_mem_hold=1, no flushes.
  - A redirect or hazard present in the same cycle is deferred, not lost. The frozen EX instruction re-presents it once mem_busy drops.
- ex_redirect (mem_busy=0): pc_write=1 (target loads), if_id_flush=1, id_ex_flush=1, if_id_write=1. lu_hazard is ignored because the ID instruction is squashed.
- lu_hazard only: pc_write=0, if_id_write=0, id_ex_flush=1. Exactly one bubble; on the next cycle the load has moved to MEM and the hazard clears.
- Otherwise: pc_write=1, if_id_write=1, all flush/hold outputs 0.
- FSM states and transitions:
  - States are RUN, LU_BUBBLE, REDIRECT and MEM_WAIT.
  - Next state is the winning priority case of this cycle: MEM_WAIT, REDIRECT, LU_BUBBLE or RUN.
  - stall_cause is the encoding of the current state: RUN=0, LU_BUBBLE=1, REDIRECT=2, MEM_WAIT=3.
- Watchdog:
  - Increments each cycle mem_busy=1 and saturates at MEM_TIMEOUT.
  - Clears when mem_busy=0.
  - When the count reaches MEM_TIMEOUT, mem_timeout sets and stays set until reset.
  - Freeze behaviour is unchanged by the timeout.
- Counters:
  - stall_cnt increments when pc_write=0 (reset cycles excluded).
  - flush_cnt increments on each accepted redirect.
  - Both saturate at all-ones and never wrap.

Decomposition:
- Shared package pipe_ctrl_pkg: stall_cause encodings (CAUSE_NONE/LOADUSE/REDIRECT/MEMWAIT) and FSM state encodings. id_ex and future stages reuse them.
- One sub-module, sat_counter (parameter WIDTH; inputs inc and clr; output count), instantiated for stall_cnt and flush_cnt.
- The watchdog remains inline.

Test Plan:
- Load-use: EX load with ex_dest=3, ID rs=3 with uses_rs=1 -> one cycle of pc_write=0, if_id_write=0, id_ex_flush=1; next cycle stall_cause=1 and stall_cnt=1.
- Zero register: ex_dest=0, id_rs=0, load in EX -> no stall while ZERO_REG_HARDWIRED=1.
- Redirect: ex_redirect=1 together with a simultaneous lu_hazard -> if_id_flush=1, id_ex_flush=1, pc_write=1; flush_cnt=1; stall_cause=2 the next cycle.
- Memory freeze with deferred redirect: mem_busy=1 for 3 cycles while ex_redirect=1 -> holds asserted, no flush for 3 cycles; flush fires in the 4th cycle; stall_cnt=3.
- Watchdog: MEM_TIMEOUT=4, mem_busy=1 for 5 cycles -> mem_timeout rises after the 4th busy cycle and stays 1 after mem_busy drops, until reset.
- Reset mid-freeze: assert reset during MEM_WAIT -> next cycle all counters=0, stall_cause=0, mem_timeout=0, both flushes=1 while reset is held.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module  : pipe_ctrl_pkg
// Brief   : Shared stall-cause and sequencer state encodings for the pipeline
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_LOADUSE  = 2'd1;
    localparam logic [1:0] CAUSE_REDIRECT = 2'd2;
    localparam logic [1:0] CAUSE_MEMWAIT  = 2'd3;

    // State encodings double as the stall_cause value reported a cycle later.
    typedef enum logic [1:0] {
        ST_RUN       = CAUSE_NONE,
        ST_LU_BUBBLE = CAUSE_LOADUSE,
        ST_REDIRECT  = CAUSE_REDIRECT,
        ST_MEM_WAIT  = CAUSE_MEMWAIT
    } state_t;

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
// ============================================================================
// Module  : sat_counter
// Brief   : Up-counter with synchronous clear that sticks at all-ones
// Revision: 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module  : hazard_ctrl
// Brief   : 5-stage pipeline sequencer: load-use bubbles, redirect squash,
//           memory freeze, memory-wait watchdog and stall/flush counters
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REGADDR_WIDTH      = 4,
    parameter bit ZERO_REG_HARDWIRED = 1'b1,
    parameter int MEM_TIMEOUT        = 64,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [REGADDR_WIDTH-1:0] id_rs,
    input  logic [REGADDR_WIDTH-1:0] id_rt,
    input  logic                     id_uses_rs,
    input  logic                     id_uses_rt,
    input  logic                     ex_mem_read,
    input  logic [REGADDR_WIDTH-1:0] ex_dest,
    input  logic                     ex_redirect,
    input  logic                     mem_busy,
    output logic                     pc_write,
    output logic                     if_id_write,
    output logic                     if_id_flush,
    output logic                     id_ex_flush,
    output logic                     id_ex_hold,
    output logic                     ex_mem_hold,
    output logic [1:0]               stall_cause,
    output logic                     mem_timeout,
    output logic [CNT_WIDTH-1:0]     stall_cnt,
    output logic [CNT_WIDTH-1:0]     flush_cnt
);

    localparam int         WD_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MEM_TIMEOUT);

    state_t            state_q;
    state_t            state_d;
    logic [WD_W-1:0]   wd_q;
    logic [WD_W-1:0]   wd_d;
    logic              timeout_q;
    logic              timeout_d;

    logic              lu_hazard;
    logic              stall_inc;
    logic              flush_inc;

    always_comb begin
        lu_hazard = ex_mem_read
                  && ((id_uses_rs && (id_rs == ex_dest)) || (id_uses_rt && (id_rt == ex_dest)))
                  && !(ZERO_REG_HARDWIRED && (ex_dest == '0));
    end

    // Pipeline controls follow the current inputs so they act in the same cycle.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        id_ex_hold  = 1'b0;
        ex_mem_hold = 1'b0;
        state_d     = ST_RUN;
        if (reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (mem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_hold  = 1'b1;
            ex_mem_hold = 1'b1;
            state_d     = ST_MEM_WAIT;
        end else if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = ST_REDIRECT;
        end else if (lu_hazard) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            state_d     = ST_LU_BUBBLE;
        end
    end

    always_comb begin
        wd_d = '0;
        if (mem_busy) begin
            wd_d = (wd_q == WD_LIMIT) ? wd_q : wd_q + 1'b1;
        end
        timeout_d = timeout_q || (wd_d == WD_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign stall_cause = state_q;
    assign mem_timeout = timeout_q;

    // pc_write is already low in reset, so the reset qualifier keeps those cycles out.
    assign stall_inc = !reset && !pc_write;
    assign flush_inc = !reset && !mem_busy && ex_redirect;

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk   (clk),
        .clr   (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_flush_cnt (
        .clk   (clk),
        .clr   (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module  : tb_hazard_ctrl
// Brief   : Directed-vector scoreboard bench for hazard_ctrl (MEM_TIMEOUT=4)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    localparam int RW = 4;
    localparam int CW = 16;

    localparam logic [5:0] C_RUN = 6'b110000;
    localparam logic [5:0] C_LU  = 6'b000100;
    localparam logic [5:0] C_RED = 6'b111100;
    localparam logic [5:0] C_MEM = 6'b000011;
    localparam logic [5:0] C_RST = 6'b001100;

    logic          clk = 1'b0;
    logic          reset;
    logic [RW-1:0] id_rs, id_rt, ex_dest;
    logic          id_uses_rs, id_uses_rt, ex_mem_read, ex_redirect, mem_busy;
    logic          pc_write, if_id_write, if_id_flush, id_ex_flush, id_ex_hold, ex_mem_hold;
    logic [1:0]    stall_cause;
    logic          mem_timeout;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks   = 0;
    int failures = 0;
    bit done     = 1'b0;

    logic [40:0] exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    hazard_ctrl #(
        .REGADDR_WIDTH      (RW),
        .ZERO_REG_HARDWIRED (1'b1),
        .MEM_TIMEOUT        (4),
        .CNT_WIDTH          (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_dest     (ex_dest),
        .ex_redirect (ex_redirect),
        .mem_busy    (mem_busy),
        .pc_write    (pc_write),
        .if_id_write (if_id_write),
        .if_id_flush (if_id_flush),
        .id_ex_flush (id_ex_flush),
        .id_ex_hold  (id_ex_hold),
        .ex_mem_hold (ex_mem_hold),
        .stall_cause (stall_cause),
        .mem_timeout (mem_timeout),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    // Drive one cycle of inputs and queue the hand-computed response for that cycle.
    task automatic vec(input string nm, input logic rst,
                       input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                       input logic urs, input logic urt, input logic mrd,
                       input logic [RW-1:0] dest, input logic redir, input logic busy,
                       input logic [5:0] ctrl, input logic [1:0] cause, input logic to,
                       input int sc, input int fc);
        @(posedge clk);
        #1;
        reset       = rst;
        id_rs       = rs;
        id_rt       = rt;
        id_uses_rs  = urs;
        id_uses_rt  = urt;
        ex_mem_read = mrd;
        ex_dest     = dest;
        ex_redirect = redir;
        mem_busy    = busy;
        exp_q.push_back({ctrl, cause, to, CW'(sc), CW'(fc)});
        name_q.push_back(nm);
    endtask

    initial begin : monitor
        logic [40:0] act;
        logic [40:0] expv;
        string       nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                expv = exp_q.pop_front();
                nm   = name_q.pop_front();
                act  = {pc_write, if_id_write, if_id_flush, id_ex_flush, id_ex_hold,
                        ex_mem_hold, stall_cause, mem_timeout, stall_cnt, flush_cnt};
                checks++;
                if (act !== expv) begin
                    failures++;
                    $display("FAIL %s: got ctrl=%b cause=%0d to=%b stall=%0d flush=%0d, want ctrl=%b cause=%0d to=%b stall=%0d flush=%0d",
                             nm, act[40:35], act[34:33], act[32], act[31:16], act[15:0],
                             expv[40:35], expv[34:33], expv[32], expv[31:16], expv[15:0]);
                end
            end
        end
    end

    initial begin : driver
        int guard;
        reset = 1'b1; id_rs = '0; id_rt = '0; ex_dest = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        ex_redirect = 1'b0; mem_busy = 1'b0;
        repeat (2) @(posedge clk);

        //   name            rst rs rt urs urt mrd dst red bsy ctrl  cause to  sc  fc
        vec("reset",          1, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 2'd0, 0,  0, 0);
        vec("idle0",          0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'd0, 0,  0, 0);
        vec("lu_rs",          0, 3, 0, 1, 0, 1, 3, 0, 0, C_LU,  2'd0, 0,  0, 0);
        vec("after_lu",       0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'd1, 0,  1, 0);
        vec("zero_reg",       0, 0, 0, 1, 0, 1, 0, 0, 0, C_RUN, 2'd0, 0,  1, 0);
        vec("lu_rt",          0, 5, 5, 0, 1, 1, 5, 0, 0, C_LU,  2'd0, 0,  1, 0);
        vec("no_uses",        0, 5, 5, 0, 0, 1, 5, 0, 0, C_RUN, 2'd1, 0,  2, 0);
        vec("redir_lu",       0, 3, 0, 1, 0, 1, 3, 1, 0, C_RED, 2'd0, 0,  2, 0);
        vec("after_redir",    0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'd2, 0,  2, 1);
        vec("busy_redir1",    0, 0, 0, 0, 0, 0, 0, 1, 1, C_MEM, 2'd0, 0,  2, 1);
        vec("busy_redir2",    0, 0, 0, 0, 0, 0, 0, 1, 1, C_MEM, 2'd3, 0,  3, 1);
        vec("busy_redir3",    0, 0, 0, 0, 0, 0, 0, 1, 1, C_MEM, 2'd3, 0,  4, 1);
        vec("deferred_redir", 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RED, 2'd3, 0,  5, 1);
        vec("idle1",          0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'd2, 0,  5, 2);
        vec("wd_busy1",       0, 0, 0, 0, 0, 0, 0, 0, 1, C_MEM, 2'd0, 0,  5, 2);
        vec("wd_busy2",       0, 0, 0, 0, 0, 0, 0, 0, 1, C_MEM, 2'd3, 0,  6, 2);
        vec("wd_busy3",       0, 0, 0, 0, 0, 0, 0, 0, 1, C_MEM, 2'd3, 0,  7, 2);
        vec("wd_busy4",       0, 0, 0, 0, 0, 0, 0, 0, 1, C_MEM, 2'd3, 0,  8, 2);
        vec("wd_busy5",       0, 0, 0, 0, 0, 0, 0, 0, 1, C_MEM, 2'd3, 1,  9, 2);
        vec("wd_sticky1",     0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'd3, 1, 10, 2);
        vec("wd_sticky2",     0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'd0, 1, 10, 2);
        vec("freeze",         0, 0, 0, 0, 0, 0, 0, 0, 1, C_MEM, 2'd0, 1, 10, 2);
        vec("reset_in_mem",   1, 0, 0, 0, 0, 0, 0, 0, 1, C_RST, 2'd3, 1, 11, 2);
        vec("reset_held",     1, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 2'd0, 0,  0, 0);
        vec("post_reset",     0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'd0, 0,  0, 0);
        vec("busy_over_lu",   0, 7, 0, 1, 0, 1, 7, 0, 1, C_MEM, 2'd0, 0,  0, 0);
        vec("deferred_lu",    0, 7, 0, 1, 0, 1, 7, 0, 0, C_LU,  2'd3, 0,  1, 0);
        vec("after_dlu",      0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'd1, 0,  2, 0);

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d responses left unchecked, want 0", exp_q.size());
        end
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
